// File: rtl/sap1_fetch_unit.sv
// SAP-1 instruction fetch stage: owns PC, MAR and IR, sequences the RAM read,
// and lends the RAM port to the execute stage while an instruction is held.
module sap1_fetch_unit #(
  parameter logic [3:0] RESET_PC   = 4'h0,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [3:0] mem_addr,
  output logic       mem_en,
  input  logic [7:0] mem_data,
  output logic       instr_valid,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  input  logic       exec_done,
  input  logic       pc_load,
  input  logic [3:0] pc_load_val,
  input  logic       exec_mem_rd,
  input  logic [3:0] exec_addr,
  output logic [3:0] pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    READ = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t     state_reg;
  logic [3:0] pc_reg;
  logic [3:0] mar_reg;
  logic [7:0] ir_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      mar_reg   <= 4'h0;
      ir_reg    <= 8'h00;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (run) state_reg <= ADDR;
        end
        ADDR: begin
          mar_reg   <= pc_reg;
          state_reg <= READ;
        end
        READ: begin
          // The only cycle the RAM is enabled for fetch, so IR never sees Z.
          ir_reg    <= mem_data;
          pc_reg    <= pc_reg + 4'd1;
          state_reg <= (mem_data[7:4] == HLT_OPCODE) ? HALT : EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            if (pc_load) pc_reg <= pc_load_val;
            state_reg <= run ? ADDR : IDLE;
          end
        end
        HALT: begin
          state_reg <= HALT;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register, so they clear with the async reset.
  assign instr_valid = (state_reg == EXEC);
  assign halted      = (state_reg == HALT);
  assign opcode      = ir_reg[7:4];
  assign operand     = ir_reg[3:0];
  assign pc          = pc_reg;

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = mar_reg;
    unique case (state_reg)
      READ: begin
        mem_en = 1'b1;
      end
      EXEC: begin
        if (exec_mem_rd) begin
          mem_en   = 1'b1;
          mem_addr = exec_addr;
        end
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed bench for sap1_fetch_unit with a 16x8 RAM model and an expected-instruction queue.
module tb_sap1_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] mem_addr;
  logic       mem_en;
  wire  [7:0] mem_data;
  logic       instr_valid;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       exec_done;
  logic       pc_load;
  logic [3:0] pc_load_val;
  logic       exec_mem_rd;
  logic [3:0] exec_addr;
  logic [3:0] pc;
  logic       halted;

  logic [7:0] ram [16];
  logic [11:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_data = mem_en ? ram[mem_addr] : 8'bz;

  sap1_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .operand     (operand),
    .exec_done   (exec_done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .exec_mem_rd (exec_mem_rd),
    .exec_addr   (exec_addr),
    .pc          (pc),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!instr_valid && cnt < budget);
    chk("valid_timeout", 8'(instr_valid), 8'h1);
  endtask

  task automatic pop_check(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'h1, 8'h0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_opcode"}, 8'(opcode), 8'(e[11:8]));
      chk({tag, "_operand"}, 8'(operand), 8'(e[7:4]));
      chk({tag, "_pc"}, 8'(pc), 8'(e[3:0]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 8'(instr_valid), 8'h0);
    chk({tag, "_halted"}, 8'(halted), 8'h0);
    chk({tag, "_mem_en"}, 8'(mem_en), 8'h0);
    chk({tag, "_mem_addr"}, 8'(mem_addr), 8'h0);
    chk({tag, "_opcode"}, 8'(opcode), 8'h0);
    chk({tag, "_operand"}, 8'(operand), 8'h0);
    chk({tag, "_pc"}, 8'(pc), 8'h0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0]  = 8'h09;
    ram[1]  = 8'h1A;
    ram[2]  = 8'hE0;
    ram[3]  = 8'hF0;
    ram[9]  = 8'h14;
    ram[15] = 8'h25;

    rst_n = 1'b0; run = 1'b0; exec_done = 1'b0; pc_load = 1'b0;
    pc_load_val = 4'h0; exec_mem_rd = 1'b0; exec_addr = 4'h0;
    step(); step();
    check_reset_outputs("reset");

    // Free-running fetch of three instructions, then HLT at address 3.
    exp_q.push_back({4'h0, 4'h9, 4'h1});
    exp_q.push_back({4'h1, 4'hA, 4'h2});
    exp_q.push_back({4'hE, 4'h0, 4'h3});
    rst_n = 1'b1; run = 1'b1; exec_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(10, cnt);
      chk($sformatf("instr%0d_spacing", k), 8'(cnt), 8'd3);
      pop_check($sformatf("instr%0d", k));
      $display("instr %0d: opcode=%h operand=%h pc=%h after %0d cycles", k, opcode, operand, pc, cnt);
    end
    cnt = 0;
    do begin
      step();
      cnt++;
      chk("hlt_no_valid", 8'(instr_valid), 8'h0);
    end while (!halted && cnt < 8);
    chk("hlt_latency", 8'(cnt), 8'd3);
    chk("hlt_pc", 8'(pc), 8'h4);
    $display("halt: halted=%b pc=%h after %0d cycles", halted, pc, cnt);
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      step();
      chk("hlt_halted_hold", 8'(halted), 8'h1);
      chk("hlt_pc_frozen", 8'(pc), 8'h4);
      chk("hlt_mem_en", 8'(mem_en), 8'h0);
      chk("hlt_valid", 8'(instr_valid), 8'h0);
    end

    // Fresh run: operand lending, stall, jump to F with wrap.
    rst_n = 1'b0; run = 1'b0; exec_done = 1'b0;
    step();
    check_reset_outputs("reset2");
    exp_q.push_back({4'h0, 4'h9, 4'h1});
    rst_n = 1'b1; run = 1'b1;
    wait_valid(10, cnt);
    pop_check("lend_instr");
    exec_mem_rd = 1'b1; exec_addr = 4'h9;
    #1;
    chk("lend_addr", 8'(mem_addr), 8'h9);
    chk("lend_en", 8'(mem_en), 8'h1);
    chk("lend_data", mem_data, 8'h14);
    $display("lend: mem_addr=%h mem_en=%b mem_data=%h", mem_addr, mem_en, mem_data);
    exec_mem_rd = 1'b0;
    #1;
    chk("lend_release_en", 8'(mem_en), 8'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 8'(instr_valid), 8'h1);
      chk("stall_opcode", 8'({opcode, operand}), 8'h09);
      chk("stall_pc", 8'(pc), 8'h1);
    end
    exec_done = 1'b1; pc_load = 1'b1; pc_load_val = 4'hF;
    step();
    exec_done = 1'b0; pc_load = 1'b0;
    chk("jump_pc", 8'(pc), 8'hF);
    chk("jump_valid_drop", 8'(instr_valid), 8'h0);
    exp_q.push_back({4'h2, 4'h5, 4'h0});
    step();
    chk("jump_read_addr", 8'(mem_addr), 8'hF);
    chk("jump_read_en", 8'(mem_en), 8'h1);
    step();
    chk("jump_valid", 8'(instr_valid), 8'h1);
    pop_check("jump_instr");
    $display("jump: opcode=%h operand=%h pc=%h", opcode, operand, pc);

    // Stop: exec_done with run low returns to IDLE and the RAM stays idle.
    exec_done = 1'b1; run = 1'b0;
    step();
    exec_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stop_valid", 8'(instr_valid), 8'h0);
      chk("stop_mem_en", 8'(mem_en), 8'h0);
      chk("stop_pc", 8'(pc), 8'h0);
      step();
    end

    // Restart from PC 0; reset asynchronously while 1A is held.
    exp_q.push_back({4'h0, 4'h9, 4'h1});
    exp_q.push_back({4'h1, 4'hA, 4'h2});
    run = 1'b1;
    wait_valid(10, cnt);
    pop_check("restart0");
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    wait_valid(10, cnt);
    pop_check("restart1");
    exec_mem_rd = 1'b1; exec_addr = 4'h9;
    #2;
    rst_n = 1'b0;
    #1;
    exec_mem_rd = 1'b0;
    check_reset_outputs("async_reset");
    $display("async reset: valid=%b mem_en=%b pc=%h", instr_valid, mem_en, pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
